noc_mm_tile_sequencer: RTL
==========================

Name: noc_mm_tile_sequencer

Overview:
Parametrised control FSM for tiled NoC matrix multiply. For each of `num_tiles` tiles it reads NUM_IN operand streams over DMA in channel order, starts the MM engine, waits for the engine's done, then writes the result tile over the output DMA. Adds a per-wait watchdog, software abort and error capture (code, stage, channel). Sits between the host register block and the DMA/MM engines.

Parameters:
- NUM_IN, 2, number of input DMA channels (1..8).
- TILE_W, 8, width of the tile count and tile index.
- TMO_W, 16, width of the watchdog limit and counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- start  in  1  level; rising edge in IDLE launches a job
- abort  in  1  level; forces ERROR from any busy state
- num_tiles  in  TILE_W  tile count, latched at launch
- tmo_limit  in  TMO_W  watchdog limit in cycles, latched at launch; 0 disables the watchdog
- start_dma_in  out  NUM_IN  one-hot, 1-cycle start pulse per input channel
- dma_in_done  in  NUM_IN  per-channel done
- dma_in_error  in  NUM_IN  per-channel error
- start_mm  out  1  1-cycle compute start pulse
- mm_done  in  1  compute complete
- start_dma_out  out  1  1-cycle write start pulse
- dma_out_done  in  1  write complete
- dma_out_error  in  1  write error
- tile_idx  out  TILE_W  current tile index, 0-based
- busy  out  1  high in READ, COMPUTE and WRITE
- done  out  1  level, high in DONE
- error  out  1  level, high in ERROR
- err_code  out  2  0 none, 1 DMA error, 2 timeout, 3 abort
- err_stage  out  2  0 READ, 1 COMPUTE, 2 WRITE
- err_chan  out  3  input channel index; valid only when err_stage is READ

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk.
  - Reset is sampled on the clk edge and overrides everything, including mid-job.
  - All outputs are 0 and the FSM is in IDLE.
  - The start-edge detector is cleared to 0. A start still held high after reset therefore counts as a rising edge.
- States: IDLE, READ, COMPUTE, WRITE, DONE, ERROR. Internal channel index `ch` is 0..NUM_IN-1.
- IDLE:
  - On a start rising edge: latch num_tiles and tmo_limit, set tile_idx=0 and ch=0.
  - If num_tiles==0, go to DONE with no pulses. Otherwise go to READ.
- Pulse rule: a start pulse is registered together with the state transition. It is high for exactly the first cycle spent in the new state (or for a new ch value). It never repeats while waiting.
- READ:
  - start_dma_in[ch] pulses on entry.
  - dma_in_error[ch] -> ERROR (code 1, stage 0, chan=ch).
  - Else dma_in_done[ch]: if ch<NUM_IN-1, ch++ and stay in READ with a new pulse. Otherwise go to COMPUTE.
  - done/error bits of channels other than ch are ignored.
- COMPUTE: start_mm pulses on entry. mm_done -> WRITE.
- WRITE:
  - start_dma_out pulses on entry.
  - dma_out_error -> ERROR (code 1, stage 2).
  - Else dma_out_done: if tile_idx==num_tiles-1, go to DONE. Otherwise tile_idx++, ch=0, go to READ.
- Simultaneous done and error in the same cycle: error wins.
- Watchdog:
  - The counter clears on every pulse and increments each waiting cycle.
  - When tmo_limit!=0 and the counter reaches tmo_limit without done/error, go to ERROR (code 2, stage = current).
  - The counter saturates and never wraps.
- Abort: in READ, COMPUTE or WRITE, abort has priority over done, error and timeout. It goes to ERROR with code 3 and stage = current. abort is ignored in IDLE, DONE and ERROR.
- DONE and ERROR:
  - done/error stay high until start is low, then return to IDLE.
  - err_* hold their values until the next launch, which clears them.
- tile_idx wraps only via relaunch; TILE_W arithmetic is unsigned.

Decomposition:
- Package noc_mm_pkg holds:
  - the state encoding localparams,
  - the ERR_NONE/ERR_DMA/ERR_TMO/ERR_ABORT codes,
  - the STG_READ/STG_COMPUTE/STG_WRITE codes.
- One sub-module, noc_mm_watchdog: loadable saturating counter with clear, enable and limit compare, TMO_W wide.

Test Plan:
- NUM_IN=2, num_tiles=3, DMAs and MM respond after 5 cycles -> pulse order per tile is in[0], in[1], mm, out. tile_idx steps 0,1,2. done rises after the third dma_out_done; total of 3 pulses per output.
- num_tiles=0, start pulse -> done high the next cycle; no start_* pulses ever.
- Tile 1, ch=1: dma_in_error[1] and dma_in_done[1] both high in the same cycle -> error=1, err_code=1, err_stage=0, err_chan=1; no start_mm.
- tmo_limit=10, mm_done never arrives -> error asserts 10 cycles after the start_mm pulse, err_code=2, err_stage=1. With tmo_limit=0 the FSM waits indefinitely.
- abort asserted during WRITE in the same cycle as dma_out_done -> ERROR with err_code=3, err_stage=2; done is never set.
- rstn low for 1 cycle mid-READ -> all outputs 0 next cycle. With start held high through reset, a fresh job launches after reset: start_dma_in[0] pulses and tile_idx=0.

Source files
------------

// File: rtl/noc_mm_pkg.sv
// Shared encodings for the tiled matrix-multiply sequencer: FSM states,
// error codes and the stage in which an error was captured.
package noc_mm_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_READ    = S_READ,
        ST_COMPUTE = S_COMPUTE,
        ST_WRITE   = S_WRITE,
        ST_DONE    = S_DONE,
        ST_ERROR   = S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_DMA   = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    localparam logic [1:0] STG_READ    = 2'd0;
    localparam logic [1:0] STG_COMPUTE = 2'd1;
    localparam logic [1:0] STG_WRITE   = 2'd2;

endpackage

// File: rtl/noc_mm_watchdog.sv
// Per-wait watchdog: the limit is loaded at job launch, the counter clears on
// every start pulse and counts each waiting cycle, saturating at all-ones.
// o_expired flags the cycle whose increment makes the count reach the limit,
// so the owner can leave the wait on that same edge. A zero limit disables it.
module noc_mm_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [TMO_W-1:0] i_load_val,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic             o_expired
);

    logic [TMO_W-1:0] r_limit;
    logic [TMO_W-1:0] r_count;
    logic [TMO_W:0]   w_count_inc;

    assign w_count_inc = {1'b0, r_count} + (TMO_W+1)'(1);
    assign o_expired   = i_enable && (r_limit != '0) && (w_count_inc >= {1'b0, r_limit});

    // Limit register and saturating wait counter; load beats clear beats count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_limit <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_limit <= i_load_val;
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + TMO_W'(1);
        end
    end

endmodule

// File: rtl/noc_mm_tile_sequencer.sv
// Tile sequencer: per tile, reads NUM_IN operand streams in channel order,
// runs the MM engine, then writes the result tile. Every wait is guarded by
// the watchdog and can be aborted; the first error is captured as
// code/stage/channel and held until the next launch.
module noc_mm_tile_sequencer
    import noc_mm_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int TILE_W = 8,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic [NUM_IN-1:0] start_dma_in,
    input  logic [NUM_IN-1:0] dma_in_done,
    input  logic [NUM_IN-1:0] dma_in_error,
    output logic              start_mm,
    input  logic              mm_done,
    output logic              start_dma_out,
    input  logic              dma_out_done,
    input  logic              dma_out_error,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [1:0]        err_stage,
    output logic [2:0]        err_chan
);

    localparam int              CH_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_IN - 1);

    state_t            r_state, w_state_nxt;
    logic              r_start_d;
    logic [CH_W-1:0]   r_ch, w_ch_nxt;
    logic [TILE_W-1:0] r_tile_idx, w_tile_nxt;
    logic [TILE_W-1:0] r_num_tiles, w_num_tiles_nxt;
    logic [NUM_IN-1:0] r_start_dma_in, w_start_dma_in_nxt;
    logic              r_start_mm, w_start_mm_nxt;
    logic              r_start_dma_out, w_start_dma_out_nxt;
    logic [1:0]        r_err_code, w_err_code_nxt;
    logic [1:0]        r_err_stage, w_err_stage_nxt;
    logic [2:0]        r_err_chan, w_err_chan_nxt;

    logic w_start_rise;
    logic w_in_done;
    logic w_in_error;
    logic w_last_tile;
    logic w_wd_load;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expired;

    assign w_start_rise = start && !r_start_d;
    assign w_in_done    = dma_in_done[r_ch];
    assign w_in_error   = dma_in_error[r_ch];
    assign w_last_tile  = (r_tile_idx == (r_num_tiles - TILE_W'(1)));

    noc_mm_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_wd_load),
        .i_load_val (tmo_limit),
        .i_clear    (w_wd_clear),
        .i_enable   (w_wd_enable),
        .o_expired  (w_wd_expired)
    );

    // Next-state, next-pulse and error-capture decisions for the job FSM.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt         = r_state;
        w_ch_nxt            = r_ch;
        w_tile_nxt          = r_tile_idx;
        w_num_tiles_nxt     = r_num_tiles;
        w_start_dma_in_nxt  = '0;
        w_start_mm_nxt      = 1'b0;
        w_start_dma_out_nxt = 1'b0;
        w_err_code_nxt      = r_err_code;
        w_err_stage_nxt     = r_err_stage;
        w_err_chan_nxt      = r_err_chan;
        w_wd_load           = 1'b0;
        w_wd_clear          = 1'b0;
        w_wd_enable         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_num_tiles_nxt = num_tiles;
                    w_tile_nxt      = '0;
                    w_ch_nxt        = '0;
                    w_err_code_nxt  = ERR_NONE;
                    w_err_stage_nxt = STG_READ;
                    w_err_chan_nxt  = '0;
                    w_wd_load       = 1'b1;
                    if (num_tiles == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt        = ST_READ;
                        w_start_dma_in_nxt = NUM_IN'(1);
                    end
                end
            end

            ST_READ: begin
                w_wd_enable = 1'b1;
                // Priority: abort, then DMA error, then done, then timeout.
                if (abort || w_in_error || (!w_in_done && w_wd_expired)) begin
                    w_state_nxt     = ST_ERROR;
                    w_err_stage_nxt = STG_READ;
                    w_err_chan_nxt  = 3'(r_ch);
                    w_err_code_nxt  = abort ? ERR_ABORT : (w_in_error ? ERR_DMA : ERR_TMO);
                end else if (w_in_done) begin
                    w_wd_clear = 1'b1;
                    if (r_ch == CH_LAST) begin
                        w_state_nxt    = ST_COMPUTE;
                        w_start_mm_nxt = 1'b1;
                    end else begin
                        w_ch_nxt           = r_ch + CH_W'(1);
                        w_start_dma_in_nxt = NUM_IN'(1) << (r_ch + CH_W'(1));
                    end
                end
            end

            ST_COMPUTE: begin
                w_wd_enable = 1'b1;
                if (abort || (!mm_done && w_wd_expired)) begin
                    w_state_nxt     = ST_ERROR;
                    w_err_stage_nxt = STG_COMPUTE;
                    w_err_chan_nxt  = '0;
                    w_err_code_nxt  = abort ? ERR_ABORT : ERR_TMO;
                end else if (mm_done) begin
                    w_state_nxt         = ST_WRITE;
                    w_start_dma_out_nxt = 1'b1;
                    w_wd_clear          = 1'b1;
                end
            end

            ST_WRITE: begin
                w_wd_enable = 1'b1;
                if (abort || dma_out_error || (!dma_out_done && w_wd_expired)) begin
                    w_state_nxt     = ST_ERROR;
                    w_err_stage_nxt = STG_WRITE;
                    w_err_chan_nxt  = '0;
                    w_err_code_nxt  = abort ? ERR_ABORT : (dma_out_error ? ERR_DMA : ERR_TMO);
                end else if (dma_out_done) begin
                    if (w_last_tile) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt        = ST_READ;
                        w_tile_nxt         = r_tile_idx + TILE_W'(1);
                        w_ch_nxt           = '0;
                        w_start_dma_in_nxt = NUM_IN'(1);
                        w_wd_clear         = 1'b1;
                    end
                end
            end

            // Terminal states hold until the host drops start.
            ST_DONE, ST_ERROR: begin
                if (!start) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, pulse and captured-error registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            r_state         <= ST_IDLE;
            r_start_d       <= 1'b0;
            r_ch            <= '0;
            r_tile_idx      <= '0;
            r_num_tiles     <= '0;
            r_start_dma_in  <= '0;
            r_start_mm      <= 1'b0;
            r_start_dma_out <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_err_stage     <= STG_READ;
            r_err_chan      <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_start_d       <= start;
            r_ch            <= w_ch_nxt;
            r_tile_idx      <= w_tile_nxt;
            r_num_tiles     <= w_num_tiles_nxt;
            r_start_dma_in  <= w_start_dma_in_nxt;
            r_start_mm      <= w_start_mm_nxt;
            r_start_dma_out <= w_start_dma_out_nxt;
            r_err_code      <= w_err_code_nxt;
            r_err_stage     <= w_err_stage_nxt;
            r_err_chan      <= w_err_chan_nxt;
        end
    end

    assign start_dma_in  = r_start_dma_in;
    assign start_mm      = r_start_mm;
    assign start_dma_out = r_start_dma_out;
    assign tile_idx      = r_tile_idx;
    assign busy          = (r_state == ST_READ) || (r_state == ST_COMPUTE) || (r_state == ST_WRITE);
    assign done          = (r_state == ST_DONE);
    assign error         = (r_state == ST_ERROR);
    assign err_code      = r_err_code;
    assign err_stage     = r_err_stage;
    assign err_chan      = r_err_chan;

endmodule
